// File: rtl/conv2d_psum_accum.sv
// conv2d_psum_accum: sums WT_DIM per-row PE partial sums into one output pixel per map position.
// Ports: clk/rst (async, active-high); start + fm_dim begin a feature map of fm_dim*fm_dim pixels;
// pe_data_i/pe_valid_i carry one partial sum per lane (no backpressure); out_data/out_valid/out_ready
// is the pixel handshake; busy spans the map, done pulses once at the end, overflow is a sticky lane drop.
module conv2d_psum_accum #(
    parameter int DWIDTH     = 32,
    parameter int WT_DIM     = 3,
    parameter int LANE_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DWIDTH-1:0]        fm_dim,
    input  logic [WT_DIM*DWIDTH-1:0] pe_data_i,
    input  logic [WT_DIM-1:0]        pe_valid_i,
    output logic [DWIDTH-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);
    localparam int AW = $clog2(LANE_DEPTH);
    localparam logic [2*DWIDTH-1:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;

    logic [2*DWIDTH-1:0] target, count;
    logic [WT_DIM-1:0]   nonempty, drop;
    logic [DWIDTH-1:0]   head [WT_DIM];
    logic [DWIDTH-1:0]   sum;
    logic                pop, xfer, last;

    // Pops are gated to RUN so a flush in DONE can never emit a pixel beyond the map.
    assign pop  = (state == RUN) && (&nonempty) && (!out_valid || out_ready);
    assign xfer = out_valid && out_ready;
    assign last = (state == RUN) && xfer && (count + ONE == target);
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_nx = state == IDLE ? (start ? (fm_dim == '0 ? DONE : RUN) : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) : IDLE;
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < WT_DIM; i++) sum = sum + head[i];
    end

    for (genvar k = 0; k < WT_DIM; k++) begin : g_lane
        logic [DWIDTH-1:0] mem [LANE_DEPTH];
        logic [AW-1:0]     wp, rp;
        logic [AW:0]       cnt;
        logic              full, push;
        assign full        = cnt == (AW+1)'(LANE_DEPTH);
        // A full lane still accepts a word when the same cycle pops, since a slot frees up.
        assign push        = (state == RUN) && pe_valid_i[k] && (!full || pop);
        assign drop[k]     = (state == RUN) && pe_valid_i[k] && full && !pop;
        assign nonempty[k] = cnt != '0;
        assign head[k]     = mem[rp];

        always_ff @(posedge clk) begin
            if (push) mem[wp] <= pe_data_i[k*DWIDTH +: DWIDTH];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else if (state == DONE) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                if (push) wp <= wp + 1'b1;
                if (pop) rp <= rp + 1'b1;
                cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            target    <= '0;
            count     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                target   <= {{DWIDTH{1'b0}}, fm_dim} * {{DWIDTH{1'b0}}, fm_dim};
                count    <= '0;
                overflow <= 1'b0;
            end
            if (state == RUN && xfer) count <= count + ONE;
            if (pop) begin
                out_data  <= sum;
                out_valid <= 1'b1;
            end else if (xfer || state == DONE) begin
                out_valid <= 1'b0;
            end
            if (|drop) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_conv2d_psum_accum.sv
// tb_conv2d_psum_accum: scoreboard bench for conv2d_psum_accum.
module tb_conv2d_psum_accum;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] fm_dim;
    logic [95:0] pe_data_i;
    logic [2:0]  pe_valid_i;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        overflow;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;

    conv2d_psum_accum dut (
        .clk(clk), .rst(rst), .start(start), .fm_dim(fm_dim),
        .pe_data_i(pe_data_i), .pe_valid_i(pe_valid_i),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pixel: got %0d, required no pixel", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_data !== mon_exp) begin
                    miscompares++;
                    $display("FAIL pixel: got %0d, required %0d", out_data, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] v, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        pe_valid_i = v;
        pe_data_i  = {c, b, a};
    endtask

    task automatic start_map(input logic [31:0] d);
        start  = 1'b1;
        fm_dim = d;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(input int n);
        logic seen = 1'b0;
        for (int i = 0; i < n && !seen; i++) begin
            if (done) seen = 1'b1;
            else tick();
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL done_timeout: done=0 after %0d cycles, required 1", n);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d pixels outstanding, required 0", exp_q.size());
        end
        tick();
    endtask

    task automatic test_reset();
        vectors += 5;
        if (out_data !== 32'd0) begin miscompares++; $display("FAIL rst_data: got %0d, required 0", out_data); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b, required 0", out_valid); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b, required 0", done); end
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL rst_ovf: got %b, required 0", overflow); end
    endtask

    task automatic test_aligned();
        logic [31:0] e [4] = '{32'd6, 32'd15, 32'd24, 32'd33};
        out_ready = 1'b1;
        start_map(32'd2);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL al_busy: got %b, required 1", busy); end
        for (int i = 0; i < 4; i++) begin
            drive(3'b111, 3*i+1, 3*i+2, 3*i+3);
            exp_q.push_back(e[i]);
            if (i >= 2) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== e[i-2]) begin
                    miscompares++;
                    $display("FAIL al_stream%0d: got v=%b d=%0d, required v=1 d=%0d", i-2, out_valid, out_data, e[i-2]);
                end
            end
            tick();
        end
        drive(3'b000, 0, 0, 0);
        tick();
        tick();
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL al_done: got done=%b busy=%b v=%b, required 1 0 0", done, busy, out_valid);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL al_idle: got done=%b busy=%b, required 0 0", done, busy);
        end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL al_drain: %0d outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_staggered();
        out_ready = 1'b1;
        start_map(32'd1);
        drive(3'b001, 5, 0, 0); tick();
        drive(3'b000, 0, 0, 0); tick();
        drive(3'b010, 0, 7, 0); tick();
        drive(3'b000, 0, 0, 0); tick(); tick();
        drive(3'b100, 0, 0, 9);
        exp_q.push_back(32'd21);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL st_early: got v=%b, required 0", out_valid); end
        tick();
        drive(3'b000, 0, 0, 0);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL st_latency0: got v=%b, required 0", out_valid); end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'd21) begin
            miscompares++;
            $display("FAIL st_pixel: got v=%b d=%0d, required v=1 d=21", out_valid, out_data);
        end
        wait_done(5);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        start_map(32'd2);
        for (int i = 0; i < 3; i++) begin
            drive(3'b111, 100*i+10, 100*i+20, 100*i+30);
            exp_q.push_back(300*i+60);
            tick();
        end
        drive(3'b000, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 32'd60 || overflow !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got v=%b d=%0d ovf=%b, required v=1 d=60 ovf=0", i, out_valid, out_data, overflow);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (out_valid !== (i < 2)) begin
                miscompares++;
                $display("FAIL bp_rate%0d: got v=%b, required %b", i, out_valid, i < 2);
            end
        end
        drive(3'b111, 1000, 2000, 3000);
        exp_q.push_back(32'd6000);
        tick();
        drive(3'b000, 0, 0, 0);
        wait_done(6);
    endtask

    task automatic test_overflow();
        out_ready = 1'b1;
        start_map(32'd2);
        for (int i = 0; i < 5; i++) begin
            drive(3'b001, 11*(i+1), 0, 0);
            tick();
            vectors++;
            if (overflow !== (i == 4)) begin
                miscompares++;
                $display("FAIL ov_push%0d: got ovf=%b, required %b", i, overflow, i == 4);
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(3'b110, 0, 1000*(i+1), 7);
            exp_q.push_back(11*(i+1) + 1000*(i+1) + 7);
            tick();
        end
        drive(3'b000, 0, 0, 0);
        wait_done(6);
        vectors++;
        if (overflow !== 1'b1) begin miscompares++; $display("FAIL ov_sticky: got %b, required 1", overflow); end
    endtask

    task automatic test_wrap_zero();
        out_ready = 1'b1;
        drive(3'b111, 50, 50, 50);
        tick();
        drive(3'b000, 0, 0, 0);
        start_map(32'd1);
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL wz_ovf_clear: got %b, required 0", overflow); end
        drive(3'b111, 32'hFFFF_FFFF, 1, 1);
        exp_q.push_back(32'd1);
        tick();
        drive(3'b000, 0, 0, 0);
        wait_done(6);
        start_map(32'd0);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (done !== (i == 0) || out_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL wz_zero%0d: got done=%b v=%b busy=%b, required %b 0 0", i, done, out_valid, busy, i == 0);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        start_map(32'd4);
        for (int i = 0; i < 3; i++) begin
            drive(3'b111, i+1, i+1, i+1);
            exp_q.push_back(3*(i+1));
            tick();
        end
        drive(3'b000, 0, 0, 0);
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rm_pre: got v=%b, required 1", out_valid); end
        rst = 1'b1;
        #1;
        exp_q.delete();
        test_reset();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rm_nodone%0d: got done=%b busy=%b, required 0 0", i, done, busy);
            end
            tick();
        end
        test_aligned();
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        fm_dim     = '0;
        pe_data_i  = '0;
        pe_valid_i = '0;
        out_ready  = 1'b1;
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_aligned();
        test_staggered();
        test_backpressure();
        test_overflow();
        test_wrap_zero();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
